hamming_encode_seq: RTL and testbench
=====================================

# hamming_encode_seq

Sequencer that drives the combinational Hamming(16,11) encoder (`program1`) over a block of data memory. It reads each 11-bit message as two bytes and presents them to the encoder. It then writes the 16-bit codeword back as two bytes and signals completion. It sits between the data memory port and the encoder, and replaces the per-message software loop with a fixed 5-cycle-per-message hardware schedule.

## Interface
- `NUM_MSGS`, 15: messages per run; legal range 1 .. 2^(ADDR_W-1).
- `SRC_BASE`, 0: byte address of the first source message.
- `DST_BASE`, 30: byte address of the first destination codeword.
- `ADDR_W`, 8: memory address width.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: run request; sampled only in IDLE or DONE.
- `BUSY` out 1: high from the first read cycle through the last write cycle.
- `DONE` out 1: high in the DONE state; held until the next accepted START or reset.
- `MEM_ADDR` out ADDR_W: memory address for the read or write.
- `MEM_WR_EN` out 1: write strobe, one cycle per byte.
- `MEM_WR_DATA` out 8: write data.
- `MEM_RD_DATA` in 8: synchronous read data, valid the cycle after `MEM_ADDR` is driven.
- `ENC_A` out 8: to encoder `regA`; equals `{5'b0, hi_q[2:0]}`.
- `ENC_B` out 8: to encoder `regB`; equals `lo_q`.
- `ENC_MSW` in 8: from encoder `MSW`.
- `ENC_LSW` in 8: from encoder `LSW`.

## Operation
- Memory layout for message i (0-based):
  - Source low byte `b8..b1` at `SRC_BASE+2i`; source high byte (`b11..b9` in bits [2:0], bits [7:3] ignored) at `SRC_BASE+2i+1`.
  - Codeword LSW goes to `DST_BASE+2i`; MSW goes to `DST_BASE+2i+1`.
- High-byte bits [7:3] are forced to 0 on `ENC_A`, so they never affect the encoder's parity.
- Registers: state, message index `idx` (ADDR_W bits), `lo_q`, `hi_q`.
- States and transitions:
  - IDLE: `START`=1 → RD_LO with `idx`=0.
  - RD_LO: `MEM_ADDR`=`SRC_BASE+2·idx` → RD_HI.
  - RD_HI: `MEM_ADDR`=`SRC_BASE+2·idx+1`; `lo_q`←`MEM_RD_DATA` → CAP.
  - CAP: `hi_q`←`MEM_RD_DATA`; `MEM_ADDR` holds its previous value → WR_LO.
  - WR_LO: `MEM_WR_EN`=1, `MEM_ADDR`=`DST_BASE+2·idx`, `MEM_WR_DATA`=`ENC_LSW` → WR_HI.
  - WR_HI: `MEM_WR_EN`=1, `MEM_ADDR`=`DST_BASE+2·idx+1`, `MEM_WR_DATA`=`ENC_MSW`.
    - If `idx`==`NUM_MSGS-1` → DONE.
    - Otherwise `idx`++ → RD_LO.
  - DONE: `DONE`=1; `START`=1 → RD_LO with `idx`=0 and `DONE` cleared.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Source/destination overlap is not checked. Reads always follow all earlier writes in program order, so an overlapping destination is read back as encoded data.
- `START` in any BUSY state is ignored; there is no queuing and no abort.

## Timing
- Reset values: state=IDLE, `idx`=0, `lo_q`=`hi_q`=0.
  - Outputs under reset: `BUSY`=0, `DONE`=0, `MEM_WR_EN`=0, `MEM_ADDR`=0, `MEM_WR_DATA`=0, `ENC_A`=`ENC_B`=0.
- `MEM_ADDR`, `MEM_WR_EN`, `MEM_WR_DATA` and `BUSY` are combinational decodes of the registered state, `idx`, and the encoder outputs. `MEM_ADDR`=0 in IDLE and DONE.
- The encoder is combinational: `ENC_*` are stable from the first cycle of WR_LO.
- Latency:
  - `START` sampled at edge k → RD_LO during cycle k+1.
  - Each message takes exactly 5 cycles.
  - `DONE` rises at edge k+5·NUM_MSGS.
- Deasserting `RESET_N` mid-run returns to IDLE immediately. Bytes already written stay in memory, and no partial write strobe is issued.

## Configuration
- `HAMMING_SEQ_CYCLE_COUNT_EN`, when defined:
  - Adds output `CYCLE_COUNT` out 16: counts cycles with `BUSY`=1, cleared on accepted `START` and on reset, saturating at 0xFFFF.
  - After a run it reads 5·NUM_MSGS.
- When undefined, the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Reset with `RESET_N`=0 mid-WR_LO → all outputs 0 the same cycle; the next `START` restarts from `idx`=0.
- `NUM_MSGS`=1, mem[0]=0x00, mem[1]=0x00, pulse `START` → mem[30]=0x00, mem[31]=0x00; `DONE` high exactly 5 cycles after `START` is sampled.
- mem[0]=0x01, mem[1]=0xF8 (upper bits must be masked) → `ENC_A`=0x00, `ENC_B`=0x01; mem[30]=0x0F, mem[31]=0x00.
- `NUM_MSGS`=15 with random source bytes → every destination pair equals the encoder reference model; exactly 30 write strobes; `BUSY` high for 75 cycles.
- `START` held high throughout a run → no restart while BUSY; `DONE` lasts one cycle, then a new run begins.
- `SRC_BASE`=0xFE, `DST_BASE`=0xFC, `NUM_MSGS`=2 → addresses wrap to 0x00/0x01 for message 1, with writes at 0xFC–0xFF.

Source files
------------

// File: rtl/hamming_encode_seq_if.sv
// Memory-port and encoder-port bundle for hamming_encode_seq.
// cycle_count exists only when HAMMING_SEQ_CYCLE_COUNT_EN is defined.
interface hamming_encode_seq_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;
  logic [7:0]        enc_a;
  logic [7:0]        enc_b;
  logic [7:0]        enc_msw;
  logic [7:0]        enc_lsw;
`ifdef HAMMING_SEQ_CYCLE_COUNT_EN
  logic [15:0]       cycle_count;
`endif

  modport master (
    input  start, mem_rd_data, enc_msw, enc_lsw,
    output busy, done, mem_addr, mem_wr_en, mem_wr_data, enc_a, enc_b
`ifdef HAMMING_SEQ_CYCLE_COUNT_EN
    , output cycle_count
`endif
  );

  modport slave (
    output start, mem_rd_data, enc_msw, enc_lsw,
    input  busy, done, mem_addr, mem_wr_en, mem_wr_data, enc_a, enc_b
`ifdef HAMMING_SEQ_CYCLE_COUNT_EN
    , input cycle_count
`endif
  );
endinterface

// File: rtl/hamming_encode_seq.sv
// Sequences Hamming(16,11) encoding over a memory block: 2 reads, 1 capture, 2 writes per message.
// Latency: 5 cycles per message, DONE at edge k+5*NUM_MSGS; no backpressure, START ignored while busy.
// Optional busy-cycle counter under HAMMING_SEQ_CYCLE_COUNT_EN.
module hamming_encode_seq #(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  hamming_encode_seq_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_CAP   = 3'd3;
  localparam logic [2:0] ST_WR_LO = 3'd4;
  localparam logic [2:0] ST_WR_HI = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [ADDR_W-1:0] SRC  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_MSGS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        lo_q;
  logic [2:0]        hi_q;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] dst_a;
  logic              busy_w;
  logic              start_ok;

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign src_a    = SRC + (idx << 1);
  assign dst_a    = DST + (idx << 1);
  assign busy_w   = (state == ST_RD_LO) || (state == ST_RD_HI) || (state == ST_CAP) ||
                    (state == ST_WR_LO) || (state == ST_WR_HI);
  assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state <= ST_RD_LO;
            idx   <= '0;
          end
        end
        ST_RD_LO: state <= ST_RD_HI;
        ST_RD_HI: begin
          lo_q  <= bus.mem_rd_data;
          state <= ST_CAP;
        end
        ST_CAP: begin
          // Only b11..b9 are kept; the upper high-byte bits never reach the encoder.
          hi_q  <= bus.mem_rd_data[2:0];
          state <= ST_WR_LO;
        end
        ST_WR_LO: state <= ST_WR_HI;
        ST_WR_HI: begin
          if (idx == LAST) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_RD_LO;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'h00;
    case (state)
      ST_RD_LO: bus.mem_addr = src_a;
      ST_RD_HI, ST_CAP: bus.mem_addr = src_a + 1'b1;
      ST_WR_LO: begin
        bus.mem_addr    = dst_a;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = bus.enc_lsw;
      end
      ST_WR_HI: begin
        bus.mem_addr    = dst_a + 1'b1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = bus.enc_msw;
      end
      default: ;
    endcase
  end

  assign bus.busy  = busy_w;
  assign bus.done  = (state == ST_DONE);
  assign bus.enc_a = {5'b0, hi_q};
  assign bus.enc_b = lo_q;

`ifdef HAMMING_SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (start_ok) begin
      cyc_q <= '0;
    end else if (busy_w && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign bus.cycle_count = cyc_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_hamming_encode_seq.sv
// Bench for hamming_encode_seq: three instances (15 msgs, wrapping bases, single msg) on a shared memory model.
// Expected writes are queued from a reference encoder when a run is launched and popped on each write strobe.
module tb_hamming_encode_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hamming_encode_seq_if #(.ADDR_W(8)) bus0 ();
  hamming_encode_seq_if #(.ADDR_W(8)) bus1 ();
  hamming_encode_seq_if #(.ADDR_W(8)) bus2 ();

  hamming_encode_seq #(.NUM_MSGS(15), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.master));
  hamming_encode_seq #(.NUM_MSGS(2), .SRC_BASE(8'hFE), .DST_BASE(8'hFC), .ADDR_W(8))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.master));
  hamming_encode_seq #(.NUM_MSGS(1), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.master));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference Hamming(16,11): bit p of the codeword is position p, bit 0 is overall parity.
  function automatic logic [15:0] ham(input logic [10:0] d);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++)
      for (int p = 1; p < 16; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b)) c[1 << b] = c[1 << b] ^ c[p];
    c[0] = ^c[15:1];
    return c;
  endfunction

  logic [15:0] cw0, cw1, cw2;
  assign cw0 = ham({bus0.enc_a[2:0], bus0.enc_b});
  assign cw1 = ham({bus1.enc_a[2:0], bus1.enc_b});
  assign cw2 = ham({bus2.enc_a[2:0], bus2.enc_b});
  assign bus0.enc_lsw = cw0[7:0];
  assign bus0.enc_msw = cw0[15:8];
  assign bus1.enc_lsw = cw1[7:0];
  assign bus1.enc_msw = cw1[15:8];
  assign bus2.enc_lsw = cw2[7:0];
  assign bus2.enc_msw = cw2[15:8];

  logic [7:0] mem [3][256];
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_addr;
  logic [7:0] ld_dat;

  always @(posedge clk) begin
    if (ld_en) mem[ld_sel][ld_addr] <= ld_dat;
    if (bus0.mem_wr_en) mem[0][bus0.mem_addr] <= bus0.mem_wr_data;
    if (bus1.mem_wr_en) mem[1][bus1.mem_addr] <= bus1.mem_wr_data;
    if (bus2.mem_wr_en) mem[2][bus2.mem_addr] <= bus2.mem_wr_data;
    bus0.mem_rd_data <= mem[0][bus0.mem_addr];
    bus1.mem_rd_data <= mem[1][bus1.mem_addr];
    bus2.mem_rd_data <= mem[2][bus2.mem_addr];
  end

  logic [17:0] sb [$];
  int busy_cnt [3];
  int wr_cnt   [3];

  task automatic sb_pop(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] d);
    logic [17:0] e;
    if (sb.size() == 0) begin
      check("sb_underflow", {14'd0, sel, a, d}, 32'h0);
    end else begin
      e = sb.pop_front();
      check("sb_write", {14'd0, sel, a, d}, {14'd0, e});
    end
  endtask

  always @(negedge clk) begin
    if (bus0.busy === 1'b1) busy_cnt[0]++;
    if (bus1.busy === 1'b1) busy_cnt[1]++;
    if (bus2.busy === 1'b1) busy_cnt[2]++;
    if (bus0.mem_wr_en === 1'b1) begin wr_cnt[0]++; sb_pop(2'd0, bus0.mem_addr, bus0.mem_wr_data); end
    if (bus1.mem_wr_en === 1'b1) begin wr_cnt[1]++; sb_pop(2'd1, bus1.mem_addr, bus1.mem_wr_data); end
    if (bus2.mem_wr_en === 1'b1) begin wr_cnt[2]++; sb_pop(2'd2, bus2.mem_addr, bus2.mem_wr_data); end
  end

  task automatic load(input int sel, input logic [7:0] a, input logic [7:0] d);
    ld_sel  = 2'(sel);
    ld_addr = a;
    ld_dat  = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  logic [7:0] sh [256];

  // Walks the run in program order on a copy of memory so overlapping regions are modelled.
  task automatic build_expect(input int sel, input logic [7:0] src, input logic [7:0] dst, input int n);
    logic [7:0]  a, d;
    logic [15:0] c;
    for (int j = 0; j < 256; j++) sh[j] = mem[sel][j];
    for (int i = 0; i < n; i++) begin
      a = src + 8'(2 * i);
      d = dst + 8'(2 * i);
      c = ham({sh[8'(a + 8'd1)][2:0], sh[a]});
      sh[d] = c[7:0];
      sb.push_back({2'(sel), d, c[7:0]});
      sh[8'(d + 8'd1)] = c[15:8];
      sb.push_back({2'(sel), 8'(d + 8'd1), c[15:8]});
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: bus0.start = v;
      1: bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  task automatic pulse_start(input int sel);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0: return bus0.done;
      1: return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  task automatic wait_done(input int sel, input int c0, input int lim, output int c);
    c = c0;
    while (c < lim && done_of(sel) !== 1'b1) begin
      @(negedge clk);
      c++;
    end
  endtask

  int cyc, b0, w0;
  logic [15:0] cwx;

  initial begin
    reset_n = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    ld_en = 1'b0;
    ld_sel = '0;
    ld_addr = '0;
    ld_dat = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",  bus0.busy, 0);
    check("rst_done",  bus0.done, 0);
    check("rst_addr",  bus0.mem_addr, 0);
    check("rst_wr_en", bus0.mem_wr_en, 0);
    check("rst_wdata", bus0.mem_wr_data, 0);
    check("rst_enc_a", bus0.enc_a, 0);
    check("rst_enc_b", bus0.enc_b, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single message of zeros.
    load(2, 8'd0, 8'h00);
    load(2, 8'd1, 8'h00);
    build_expect(2, 8'h00, 8'd30, 1);
    b0 = busy_cnt[2];
    w0 = wr_cnt[2];
    pulse_start(2);
    wait_done(2, 0, 40, cyc);
    check("n1_done_latency", cyc, 5);
    check("n1_mem30", mem[2][30], 8'h00);
    check("n1_mem31", mem[2][31], 8'h00);
    check("n1_writes", wr_cnt[2] - w0, 2);
    check("n1_busy_cycles", busy_cnt[2] - b0, 5);
    check("n1_sb_drain", sb.size(), 0);

    // 15 messages, first one with masked high bits, rest random.
    for (int i = 0; i < 30; i++)
      load(0, 8'(i), (i == 0) ? 8'h01 : (i == 1) ? 8'hF8 : 8'($urandom_range(0, 255)));
    build_expect(0, 8'h00, 8'd30, 15);
    b0 = busy_cnt[0];
    w0 = wr_cnt[0];
    pulse_start(0);
    repeat (3) @(negedge clk);
    check("mask_enc_a", bus0.enc_a, 8'h00);
    check("mask_enc_b", bus0.enc_b, 8'h01);
    check("wr_lo_addr", bus0.mem_addr, 8'd30);
    check("wr_lo_strobe", bus0.mem_wr_en, 1);
    wait_done(0, 3, 200, cyc);
    check("n15_done_latency", cyc, 75);
    check("n15_writes", wr_cnt[0] - w0, 30);
    check("n15_busy_cycles", busy_cnt[0] - b0, 75);
    check("mask_mem30", mem[0][30], 8'h0F);
    check("mask_mem31", mem[0][31], 8'h00);
    check("n15_sb_drain", sb.size(), 0);
`ifdef HAMMING_SEQ_CYCLE_COUNT_EN
    check("cycle_count", bus0.cycle_count, 75);
`endif

    // START held high: no restart while busy, DONE for one cycle, then a new run.
    load(2, 8'd0, 8'($urandom_range(0, 255)));
    load(2, 8'd1, 8'($urandom_range(0, 255)));
    build_expect(2, 8'h00, 8'd30, 1);
    build_expect(2, 8'h00, 8'd30, 1);
    w0 = wr_cnt[2];
    set_start(2, 1'b1);
    @(negedge clk);
    wait_done(2, 0, 40, cyc);
    check("hold_first_done", cyc, 5);
    check("hold_first_writes", wr_cnt[2] - w0, 2);
    @(negedge clk);
    check("hold_done_one_cycle", bus2.done, 0);
    check("hold_restart_busy", bus2.busy, 1);
    set_start(2, 1'b0);
    wait_done(2, 6, 40, cyc);
    check("hold_second_done", cyc, 11);
    check("hold_total_writes", wr_cnt[2] - w0, 4);
    check("hold_sb_drain", sb.size(), 0);

    // Reset in the middle of WR_LO: only that first strobe may land.
    cwx = ham({mem[0][1][2:0], mem[0][0]});
    sb.push_back({2'd0, 8'd30, cwx[7:0]});
    pulse_start(0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy",  bus0.busy, 0);
    check("mid_rst_done",  bus0.done, 0);
    check("mid_rst_addr",  bus0.mem_addr, 0);
    check("mid_rst_wr_en", bus0.mem_wr_en, 0);
    check("mid_rst_wdata", bus0.mem_wr_data, 0);
    check("mid_rst_enc_a", bus0.enc_a, 0);
    check("mid_rst_enc_b", bus0.enc_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_sb_drain", sb.size(), 0);
    build_expect(0, 8'h00, 8'd30, 15);
    pulse_start(0);
    wait_done(0, 0, 200, cyc);
    check("restart_done_latency", cyc, 75);
    check("restart_sb_drain", sb.size(), 0);

    // Wrapping addresses: source 0xFE,0xFF,0x00,0x01; destination 0xFC..0xFF.
    load(1, 8'hFE, 8'($urandom_range(0, 255)));
    load(1, 8'hFF, 8'($urandom_range(0, 255)));
    load(1, 8'h00, 8'($urandom_range(0, 255)));
    load(1, 8'h01, 8'($urandom_range(0, 255)));
    build_expect(1, 8'hFE, 8'hFC, 2);
    w0 = wr_cnt[1];
    pulse_start(1);
    repeat (5) @(negedge clk);
    check("wrap_rd_lo_addr", bus1.mem_addr, 8'h00);
    @(negedge clk);
    check("wrap_rd_hi_addr", bus1.mem_addr, 8'h01);
    wait_done(1, 6, 40, cyc);
    check("wrap_done_latency", cyc, 10);
    check("wrap_writes", wr_cnt[1] - w0, 4);
    check("wrap_sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
